// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl: raster read sequencer for one frame of the pixel frame
// memory feeding the 3x3 line-buffer/window datapath.
//  - One read per pacing strobe iEn while scanning; iBusy drops the strobe.
//  - oPixValid/oRow/oCol/oWinValid describe the read issued one cycle earlier,
//    matching the 1-cycle synchronous memory latency.
//  - oRdEn is a decode of the registered state and the live strobe. This puts
//    the read in the same cycle as the strobe it answers.
//  - oDone pulses for one cycle after the final pixel has been presented.
module frame_scan_ctrl #(
    parameter int IMG_W  = 480,
    parameter int IMG_H  = 272,
    parameter int ADDR_W = 17,
    parameter int COL_W  = $clog2(IMG_W),
    parameter int ROW_W  = $clog2(IMG_H)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic              iEn,
    input  logic              iBusy,
    output logic              oRdEn,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oPixValid,
    output logic [ROW_W-1:0]  oRow,
    output logic [COL_W-1:0]  oCol,
    output logic              oWinValid,
    output logic              oActive,
    output logic              oDone
);

    localparam int                NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NPIX - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_MIN   = ROW_W'(2);
    localparam logic [COL_W-1:0]  COL_MIN   = COL_W'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              pix_vld_q;
    logic              win_vld_q;
    logic [ROW_W-1:0]  pix_row_q;
    logic [COL_W-1:0]  pix_col_q;
    logic              active_q;
    logic              done_q;
    logic              fire;
    logic              last_fire;
    logic              win_hit;

    // A read fires on a live strobe while scanning and not stalled
    assign fire      = (state_q == S_SCAN) && iEn && !iBusy;
    assign last_fire = fire && (addr_q == ADDR_LAST);
    // Window is complete once two full rows and two columns precede the pixel
    assign win_hit   = (row_q >= ROW_MIN) && (col_q >= COL_MIN);

    // Next raster position: cleared on start, advanced on every non-final read
    always_comb begin
        addr_d = addr_q;
        row_d  = row_q;
        col_d  = col_q;
        if (state_q == S_IDLE && iStart) begin
            addr_d = '0;
            row_d  = '0;
            col_d  = '0;
        end else if (fire && !last_fire) begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Scan FSM, raster counters and the registered pixel/window/status outputs
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pix_vld_q <= 1'b0;
            win_vld_q <= 1'b0;
            pix_row_q <= '0;
            pix_col_q <= '0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pix_vld_q <= fire;
            win_vld_q <= fire && win_hit;
            if (fire) begin
                pix_row_q <= row_q;
                pix_col_q <= col_q;
            end
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (iStart) begin
                        state_q  <= S_SCAN;
                        active_q <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (last_fire) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state_q  <= S_DONE;
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign oRdEn     = fire;
    assign oAddr     = addr_q;
    assign oPixValid = pix_vld_q;
    assign oRow      = pix_row_q;
    assign oCol      = pix_col_q;
    assign oWinValid = win_vld_q;
    assign oActive   = active_q;
    assign oDone     = done_q;

endmodule
